string_matcher: RTL
===================

STRING_MATCHER -- requirements
Module: string_matcher

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of the word scanned per run.
REQ-002 SHALL have parameter PAT_MAX, default 8: maximum pattern length in bits.
REQ-003 SHALL have parameter CNT_W, default 16: width of the match counter.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port clr  input  1: synchronous, active-high reset.
REQ-006 SHALL have port en  input  1: start pulse; latches run inputs when idle or done.
REQ-007 SHALL have port din  input  DATA_W: word to scan, LSB-first.
REQ-008 SHALL have port pat  input  PAT_MAX: pattern; pat[0] is the earliest bit of a match window.
REQ-009 SHALL have port pat_len  input  clog2(PAT_MAX+1): active pattern length.
REQ-010 SHALL have port overlap  input  1: 1 = overlapping matches counted, 0 = non-overlapping.
REQ-011 SHALL have port count  output  CNT_W: matches found in current/last run.
REQ-012 SHALL have port match  output  1: one-cycle pulse on each counted match.
REQ-013 SHALL have port busy  output  1: high while scanning.
REQ-014 SHALL have port done  output  1: high from run end until next start or clr.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL, in IDLE or DONE with en=1, latch din/pat/pat_len/overlap, clear count, clear history, load bit index 0, and enter RUN.
REQ-017 SHALL ignore en while in RUN; latched run inputs stay unchanged.
REQ-018 SHALL, in RUN, consume exactly one din bit per cycle, bit i in the (i+1)th cycle after the en cycle, for DATA_W cycles.
REQ-019 SHALL keep a history of the last PAT_MAX bits and a fill counter of bits received since start or since last non-overlap match.
REQ-020 SHALL declare a match in the cycle bit i is consumed when fill >= pat_len and the last pat_len bits, oldest first, equal pat[pat_len-1:0].
REQ-021 SHALL, on match, pulse match and increment count in the same cycle; count saturates at 2^CNT_W-1, while match still pulses.
REQ-022 SHALL, when overlap=0, reset fill to 0 after a match so the next match needs pat_len fresh bits.
REQ-023 SHALL never match when pat_len=0 or pat_len>PAT_MAX; the run still completes normally.
REQ-024 SHALL leave RUN after consuming bit DATA_W-1, enter DONE next cycle with busy=0 and done=1, and hold count.
REQ-025 SHALL drive busy=1 exactly in RUN and done=1 exactly in DONE.
REQ-026 SHALL treat matches spanning two runs as impossible; history is cleared on every start.

Reset
REQ-027 SHALL, on clr=1 at a clock edge, enter IDLE with count=0, match=0, busy=0, done=0, history and fill cleared.
REQ-028 SHALL give clr priority over en in the same cycle; a run in progress is abandoned.
REQ-029 SHALL require no reset other than clr; outputs are defined from the first edge with clr high.

Structure
REQ-030 SHALL place the state encoding (IDLE/RUN/DONE) and parameter defaults in shared package string_matcher_pkg.
REQ-031 SHALL factor history register, fill counter and masked compare into sub-module string_matcher_win; the top holds FSM, bit index, and counter.

Verification
REQ-032 SHALL verify overlap: pat=8'h05, pat_len=3, overlap=1, din=16'h0015 -> match pulses when bits 2 and 4 are consumed, count=2, done after 16 RUN cycles.
REQ-033 SHALL verify non-overlap: same stimulus with overlap=0 -> single match on bit 2, count=1.
REQ-034 SHALL verify saturation: bench CNT_W=2, pat=1, pat_len=1, din=16'hFFFF -> count=3 at done, match pulses 16 times.
REQ-035 SHALL verify busy and abort: en pulse mid-run with new din -> ignored; clr at bit 7 -> next cycle IDLE, count=0, busy=0, done=0.
REQ-036 SHALL verify degenerate length: pat_len=0 and pat_len=PAT_MAX+1 with din=16'hFFFF -> count=0, no match pulse, done asserted.
REQ-037 SHALL verify restart: en in DONE -> count cleared to 0, busy=1 on the next cycle, and no match before pat_len bits are consumed.

Source files
------------

// File: rtl/string_matcher_pkg.sv
// Shared definitions for the serial bit-pattern matcher.
// Holds the run FSM encoding and the default geometry.
package string_matcher_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_PAT_MAX = 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/string_matcher_win.sv
// Sliding bit window: history shift register, fill counter
// and masked compare of the newest pat_len bits against pat.
module string_matcher_win
    import string_matcher_pkg::*;
#(
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int LW      = $clog2(DEF_PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               shift,
    input  logic               bit_in,
    input  logic [PAT_MAX-1:0] pat,
    input  logic [LW-1:0]      pat_len,
    input  logic               overlap,
    output logic               hit
);

    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [PAT_MAX-1:0] shifted;
    logic [PAT_MAX-1:0] win;
    logic [PAT_MAX-1:0] mask;
    logic [LW-1:0]      fill_inc;
    logic               len_ok;
    logic               eq;

    // Newest bit enters at the top, so the oldest of the last
    // pat_len bits sits at index PAT_MAX-pat_len and lines up
    // with pat[0] after the right shift.
    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        hit      = 1'b0;
        shifted  = {bit_in, hist_q[PAT_MAX-1:1]};
        fill_inc = (fill_q == LW'(PAT_MAX)) ? fill_q : fill_q + 1'b1;
        len_ok   = (pat_len != '0) && (pat_len <= LW'(PAT_MAX));
        for (int k = 0; k < PAT_MAX; k++) begin
            mask[k] = (LW'(k) < pat_len);
        end
        win = shifted >> (LW'(PAT_MAX) - pat_len);
        eq  = (((win ^ pat) & mask) == '0);
        if (start) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift) begin
            hit    = len_ok && (fill_inc >= pat_len) && eq;
            hist_d = shifted;
            fill_d = (hit && !overlap) ? '0 : fill_inc;
        end
    end

    // Window state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/string_matcher.sv
// Scans one latched word LSB-first, one bit per cycle, and
// counts occurrences of a short bit pattern.
module string_matcher
    import string_matcher_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         en,
    input  logic [DATA_W-1:0]            din,
    input  logic [PAT_MAX-1:0]           pat,
    input  logic [$clog2(PAT_MAX+1)-1:0] pat_len,
    input  logic                         overlap,
    output logic [CNT_W-1:0]             count,
    output logic                         match,
    output logic                         busy,
    output logic                         done
);

    localparam int LW    = $clog2(PAT_MAX + 1);
    localparam int IDX_W = $clog2(DATA_W);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               start;
    logic               shift;
    logic               hit;

    string_matcher_win #(
        .PAT_MAX (PAT_MAX),
        .LW      (LW)
    ) u_win (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .shift   (shift),
        .bit_in  (din_q[idx_q]),
        .pat     (pat_q),
        .pat_len (len_q),
        .overlap (ovl_q),
        .hit     (hit)
    );

    // Next-state logic: start a run from IDLE/DONE, step one
    // bit per cycle in RUN, count hits with saturation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        din_d   = din_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        start   = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (en) begin
                    din_d   = din;
                    pat_d   = pat;
                    len_d   = pat_len;
                    ovl_d   = overlap;
                    cnt_d   = '0;
                    idx_d   = '0;
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                shift = 1'b1;
                if (hit) begin
                    match_d = 1'b1;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(DATA_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run FSM and datapath registers; clr wins over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            din_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    assign count = cnt_q;
    assign match = match_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);

endmodule
